// File: rtl/mgmt_sram_arbiter.sv
// Multi-bank DFFRAM controller: Wishbone slave plus read-only housekeeping port with starvation guard.
// Optional feature: define MGMT_SRAM_WB_ERR_EN to answer out-of-range WB accesses with wb_err_o.
module mgmt_sram_arbiter #(
  parameter int AW         = 8,
  parameter int BANKS      = 2,
  parameter int STARVE_MAX = 4,
  localparam int BW        = (BANKS > 1) ? $clog2(BANKS) : 1,
  localparam int IW        = AW + BW
) (
  input  logic                  core_clk,
  input  logic                  core_rst,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  input  logic                  ro_req,
  input  logic [IW-1:0]         ro_addr,
  output logic [31:0]           ro_data,
  output logic                  ro_valid,
  output logic [BANKS-1:0]      mem_en,
  output logic [4*BANKS-1:0]    mem_we,
  output logic [AW*BANKS-1:0]   mem_a,
  output logic [32*BANKS-1:0]   mem_di,
  input  logic [32*BANKS-1:0]   mem_do
);

  localparam int SW = $clog2(STARVE_MAX + 1);

`ifdef MGMT_SRAM_WB_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WB_RD, RO_RD, RESP} state_e;

  state_e          state_q;
  logic [SW-1:0]   starveCnt_q, starveCnt_d;
  logic [BW-1:0]   bank_q;
  logic            oor_q;
  logic [31:0]     wbDat_q, roData_q;
  logic            wbAck_q, wbErr_q, roValid_q;

  logic [IW-1:0]   wbIdx, issueIdx;
  logic [BW-1:0]   issueBank;
  logic [AW-1:0]   issueAddr;
  logic            issueOor, wbReq, starved, grantRo, grantWb;
  logic [31:0]     rdWord, rdData;
  logic            unusedAdr;

  assign wbIdx     = wb_adr_i[IW+1:2];
  assign unusedAdr = ^{wb_adr_i[31:IW+2], wb_adr_i[1:0]};

  assign wbReq   = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign starved = ro_req & (starveCnt_q == SW'(STARVE_MAX));
  assign grantRo = (state_q == IDLE) & ~core_rst & ro_req & (~wbReq | starved);
  assign grantWb = (state_q == IDLE) & ~core_rst & wbReq & ~grantRo;

  assign issueIdx  = grantRo ? ro_addr : wbIdx;
  assign issueBank = issueIdx[IW-1:AW];
  assign issueAddr = issueIdx[AW-1:0];
  // Only reachable when BANKS is not a power of two.
  assign issueOor  = {1'b0, issueBank} >= (BW+1)'(BANKS);

  assign mem_a  = {BANKS{issueAddr}};
  assign mem_di = {BANKS{wb_dat_i}};

  always_comb begin
    mem_en = '0;
    mem_we = '0;
    for (int b = 0; b < BANKS; b++) begin
      if ((grantRo | grantWb) & ~issueOor & (issueBank == BW'(b))) begin
        mem_en[b] = 1'b1;
        if (grantWb & wb_we_i) mem_we[4*b +: 4] = wb_sel_i;
      end
    end
  end

  always_comb begin
    rdWord = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (bank_q == BW'(b)) rdWord = mem_do[32*b +: 32];
    end
  end

  assign rdData = oor_q ? 32'h0 : rdWord;

  // Counts WB grants taken while RO waits; clears whenever RO is served or stops asking.
  always_comb begin
    starveCnt_d = starveCnt_q;
    if (!ro_req || grantRo) begin
      starveCnt_d = '0;
    end else if (grantWb && (starveCnt_q != SW'(STARVE_MAX))) begin
      starveCnt_d = starveCnt_q + 1'b1;
    end
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_q     <= IDLE;
      starveCnt_q <= '0;
      bank_q      <= '0;
      oor_q       <= 1'b0;
      wbDat_q     <= '0;
      roData_q    <= '0;
      wbAck_q     <= 1'b0;
      wbErr_q     <= 1'b0;
      roValid_q   <= 1'b0;
    end else begin
      starveCnt_q <= starveCnt_d;
      case (state_q)
        IDLE: begin
          bank_q <= issueBank;
          oor_q  <= issueOor;
          if (grantRo) begin
            state_q <= RO_RD;
          end else if (grantWb) begin
            if (wb_we_i) begin
              state_q <= RESP;
              if (issueOor && ErrEn) begin
                wbErr_q <= 1'b1;
                wbDat_q <= '0;
              end else begin
                wbAck_q <= 1'b1;
              end
            end else begin
              state_q <= WB_RD;
            end
          end
        end
        WB_RD: begin
          state_q <= RESP;
          if (oor_q && ErrEn) begin
            wbErr_q <= 1'b1;
            wbDat_q <= '0;
          end else begin
            wbAck_q <= 1'b1;
            wbDat_q <= rdData;
          end
        end
        RO_RD: begin
          state_q   <= RESP;
          roValid_q <= 1'b1;
          roData_q  <= rdData;
        end
        RESP: begin
          state_q   <= IDLE;
          wbAck_q   <= 1'b0;
          wbErr_q   <= 1'b0;
          roValid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb_dat_o = wbDat_q;
  assign wb_ack_o = wbAck_q;
  assign wb_err_o = wbErr_q;
  assign ro_data  = roData_q;
  assign ro_valid = roValid_q;

endmodule

// File: tb/tb_mgmt_sram_arbiter.sv
// Directed bench for mgmt_sram_arbiter: a 2-bank instance with a memory model and a 3-bank instance
// with constant bank data for out-of-range cases.
module tb_mgmt_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cycA = 1'b0, cycB = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, datIn = '0;

  logic [31:0] datA, roDataA;
  logic        ackA, errA, roValidA, roReqA = 1'b0;
  logic [8:0]  roAddrA = '0;
  logic [1:0]  enA;
  logic [7:0]  weA;
  logic [15:0] aA;
  logic [63:0] diA, doA;

  logic [31:0] datB, roDataB;
  logic        ackB, errB, roValidB, roReqB = 1'b0;
  logic [9:0]  roAddrB = '0;
  logic [2:0]  enB;
  logic [11:0] weB;
  logic [23:0] aB;
  logic [95:0] diB;
  logic [95:0] doB = {32'hA5A5A5A5, 32'h5A5A5A5A, 32'h3C3C3C3C};

  int checks = 0;
  int failures = 0;

  logic [31:0] memArr [2][256];
  logic [31:0] doReg  [2];

  always #5 clk = ~clk;

  mgmt_sram_arbiter #(.AW(8), .BANKS(2), .STARVE_MAX(4)) dutA (
    .core_clk(clk), .core_rst(rst),
    .wb_cyc_i(cycA), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
    .wb_adr_i(adr), .wb_dat_i(datIn), .wb_dat_o(datA), .wb_ack_o(ackA), .wb_err_o(errA),
    .ro_req(roReqA), .ro_addr(roAddrA), .ro_data(roDataA), .ro_valid(roValidA),
    .mem_en(enA), .mem_we(weA), .mem_a(aA), .mem_di(diA), .mem_do(doA)
  );

  mgmt_sram_arbiter #(.AW(8), .BANKS(3), .STARVE_MAX(4)) dutB (
    .core_clk(clk), .core_rst(rst),
    .wb_cyc_i(cycB), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
    .wb_adr_i(adr), .wb_dat_i(datIn), .wb_dat_o(datB), .wb_ack_o(ackB), .wb_err_o(errB),
    .ro_req(roReqB), .ro_addr(roAddrB), .ro_data(roDataB), .ro_valid(roValidB),
    .mem_en(enB), .mem_we(weB), .mem_a(aB), .mem_di(diB), .mem_do(doB)
  );

  // DFFRAM model: read-before-write, data one cycle after EN.
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (enA[b]) begin
        doReg[b] <= memArr[b][aA[8*b +: 8]];
        for (int k = 0; k < 4; k++) begin
          if (weA[4*b+k]) memArr[b][aA[8*b +: 8]][8*k +: 8] = diA[32*b+8*k +: 8];
        end
      end
    end
  end
  assign doA = {doReg[1], doReg[0]};

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic ca, input logic cb, input logic w, input logic [3:0] s,
                               input logic [31:0] a, input logic [31:0] d);
    cycA  = ca;
    cycB  = cb;
    stb   = ca | cb;
    we    = w;
    sel   = s;
    adr   = a;
    datIn = d;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 256; i++) memArr[b][i] = '0;
    doReg[0] = '0;
    doReg[1] = '0;
    memArr[0][8'hFF] = 32'h12345678;
    memArr[0][8'h10] = 32'hCAFEF00D;
    memArr[0][8'h20] = 32'h0BADF00D;
    memArr[1][8'h06] = 32'h600DD00D;

    // Reset state
    tick();
    tick();
    checkOutput("rst_ack", {63'b0, ackA}, 64'd0);
    checkOutput("rst_err", {63'b0, errA}, 64'd0);
    checkOutput("rst_en", {62'b0, enA}, 64'd0);
    checkOutput("rst_we", {56'b0, weA}, 64'd0);
    checkOutput("rst_dat", {32'b0, datA}, 64'd0);
    checkOutput("rst_rovalid", {63'b0, roValidA}, 64'd0);
    checkOutput("rst_rodata", {32'b0, roDataA}, 64'd0);

    // Clear word 0x105, then byte-masked write and readback
    @(negedge clk); rst = 1'b0; applyStimulus(1, 0, 1, 4'hF, 32'h414, 32'h0); #1;
    checkOutput("wr0_en", {62'b0, enA}, 64'h2);
    tick();
    checkOutput("wr0_ack", {63'b0, ackA}, 64'd1);
    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk); applyStimulus(1, 0, 1, 4'b0101, 32'h414, 32'hDEADBEEF); #1;
    checkOutput("wr_en", {62'b0, enA}, 64'h2);
    checkOutput("wr_we", {56'b0, weA}, 64'h50);
    checkOutput("wr_a", {48'b0, aA}, 64'h0505);
    tick();
    checkOutput("wr_ack", {63'b0, ackA}, 64'd1);
    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk); applyStimulus(1, 0, 0, 4'hF, 32'h414, 32'h0); #1;
    checkOutput("rb_en", {62'b0, enA}, 64'h2);
    checkOutput("rb_we", {56'b0, weA}, 64'h0);
    tick();
    checkOutput("rb_ack_n1", {63'b0, ackA}, 64'd0);
    tick();
    checkOutput("rb_ack", {63'b0, ackA}, 64'd1);
    checkOutput("rb_dat", {32'b0, datA}, 64'h00AD00EF);
    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0);

    // Bank0 word 0xFF, stb held through the ack cycle
    @(negedge clk); applyStimulus(1, 0, 0, 4'hF, 32'h3FC, 32'h0); #1;
    checkOutput("ff_en", {62'b0, enA}, 64'h1);
    tick();
    checkOutput("ff_ack_n1", {63'b0, ackA}, 64'd0);
    tick();
    checkOutput("ff_ack", {63'b0, ackA}, 64'd1);
    checkOutput("ff_dat", {32'b0, datA}, 64'h12345678);
    checkOutput("ff_noreissue", {62'b0, enA}, 64'h0);
    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0);
    tick();
    checkOutput("ff_ack_n3", {63'b0, ackA}, 64'd0);

    // Simultaneous requests, counter at 0: WB first, RO right after the ack
    @(negedge clk); applyStimulus(1, 0, 0, 4'hF, 32'h40, 32'h0);
    roReqA = 1'b1; roAddrA = 9'h105; #1;
    checkOutput("arb_wbfirst", {62'b0, enA}, 64'h1);
    tick();
    tick();
    checkOutput("arb_ack", {63'b0, ackA}, 64'd1);
    checkOutput("arb_dat", {32'b0, datA}, 64'hCAFEF00D);
    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0);
    tick();
    checkOutput("arb_ro_en", {62'b0, enA}, 64'h2);
    checkOutput("arb_ro_a", {48'b0, aA}, 64'h0505);
    tick();
    checkOutput("arb_ro_valid_n1", {63'b0, roValidA}, 64'd0);
    tick();
    checkOutput("arb_ro_valid", {63'b0, roValidA}, 64'd1);
    checkOutput("arb_ro_data", {32'b0, roDataA}, 64'h00AD00EF);
    roReqA = 1'b0;

    // Back-to-back WB reads with RO pending: four WB grants then RO
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c == 0) begin
        applyStimulus(1, 0, 0, 4'hF, 32'h80, 32'h0);
        roReqA = 1'b1; roAddrA = 9'h106;
      end
      #1;
      if (c == 0 || c == 3 || c == 6 || c == 9) checkOutput($sformatf("starve_wb%0d", c), {62'b0, enA}, 64'h1);
      if (c == 2) checkOutput("starve_dat", {32'b0, datA}, 64'h0BADF00D);
      if (c == 12) checkOutput("starve_ro_en", {62'b0, enA}, 64'h2);
      if (c == 13) checkOutput("starve_ro_valid_n1", {63'b0, roValidA}, 64'd0);
      if (c == 14) begin
        checkOutput("starve_ro_valid", {63'b0, roValidA}, 64'd1);
        checkOutput("starve_ro_data", {32'b0, roDataA}, 64'h600DD00D);
        applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0);
        roReqA = 1'b0;
      end
    end

    // Reset while in WB_RD drops the ack
    @(negedge clk); applyStimulus(1, 0, 0, 4'hF, 32'h3FC, 32'h0); #1;
    checkOutput("mrst_en", {62'b0, enA}, 64'h1);
    @(negedge clk); rst = 1'b1; applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0); #1;
    checkOutput("mrst_en_inrst", {62'b0, enA}, 64'h0);
    @(negedge clk); rst = 1'b0; #1;
    checkOutput("mrst_ack", {63'b0, ackA}, 64'd0);
    checkOutput("mrst_dat", {32'b0, datA}, 64'd0);
    checkOutput("mrst_en_after", {62'b0, enA}, 64'h0);
    checkOutput("mrst_we_after", {56'b0, weA}, 64'h0);
    @(negedge clk); applyStimulus(1, 0, 0, 4'hF, 32'h3FC, 32'h0); #1;
    checkOutput("mrst_fresh_en", {62'b0, enA}, 64'h1);
    tick();
    tick();
    checkOutput("mrst_fresh_ack", {63'b0, ackA}, 64'd1);
    checkOutput("mrst_fresh_dat", {32'b0, datA}, 64'h12345678);
    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0);

    // Three banks: valid bank2 read, then out-of-range read and write
    @(negedge clk); applyStimulus(0, 1, 0, 4'hF, 32'h814, 32'h0); #1;
    checkOutput("b3_en", {61'b0, enB}, 64'h4);
    tick();
    tick();
    checkOutput("b3_ack", {63'b0, ackB}, 64'd1);
    checkOutput("b3_dat", {32'b0, datB}, 64'hA5A5A5A5);
    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk); applyStimulus(0, 1, 0, 4'hF, 32'hC14, 32'h0); #1;
    checkOutput("oor_rd_en", {61'b0, enB}, 64'h0);
    tick();
    checkOutput("oor_rd_n1", {62'b0, ackB, errB}, 64'd0);
    tick();
`ifdef MGMT_SRAM_WB_ERR_EN
    checkOutput("oor_rd_resp", {62'b0, ackB, errB}, 64'b01);
`else
    checkOutput("oor_rd_resp", {62'b0, ackB, errB}, 64'b10);
`endif
    checkOutput("oor_rd_dat", {32'b0, datB}, 64'h0);
    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk); applyStimulus(0, 1, 1, 4'hF, 32'hC14, 32'h55555555); #1;
    checkOutput("oor_wr_en", {61'b0, enB}, 64'h0);
    checkOutput("oor_wr_we", {52'b0, weB}, 64'h0);
    tick();
`ifdef MGMT_SRAM_WB_ERR_EN
    checkOutput("oor_wr_resp", {62'b0, ackB, errB}, 64'b01);
`else
    checkOutput("oor_wr_resp", {62'b0, ackB, errB}, 64'b10);
`endif
    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0);

    // Three banks: RO valid read, then RO out-of-range read
    @(negedge clk); roReqB = 1'b1; roAddrB = 10'h205; #1;
    checkOutput("ro3_en", {61'b0, enB}, 64'h4);
    tick();
    tick();
    checkOutput("ro3_valid", {63'b0, roValidB}, 64'd1);
    checkOutput("ro3_data", {32'b0, roDataB}, 64'hA5A5A5A5);
    roReqB = 1'b0;
    @(negedge clk); roReqB = 1'b1; roAddrB = 10'h305; #1;
    checkOutput("rooor_en", {61'b0, enB}, 64'h0);
    tick();
    tick();
    checkOutput("rooor_valid", {63'b0, roValidB}, 64'd1);
    checkOutput("rooor_data", {32'b0, roDataB}, 64'h0);
    roReqB = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
